ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 131 +++++++++++++
 tb/tb_ifetch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch unit: one outstanding imem read, single instruction register
// toward decode, and redirect handling that drops a stale in-flight response.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [3:0]  opcode,
    output logic [3:0]  opfunc,
    output logic [31:0] ir_pc4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_FULL    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] stale_pc_q, stale_pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc4_q, ir_pc4_d;
    logic        ir_valid_q, ir_valid_d;

    logic [31:0] target_s;
    logic [31:0] pc_inc_s;

    assign target_s = {redirect_pc[31:2], 2'b00};
    assign pc_inc_s = fetch_pc_q + 32'd4;

    // Next-state, fetch address and instruction register update; redirect wins.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        stale_pc_d = stale_pc_q;
        ir_d       = ir_q;
        ir_pc4_d   = ir_pc4_q;
        ir_valid_d = ir_valid_q;
        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    fetch_pc_d = target_s;
                    ir_valid_d = 1'b0;
                    if (imem_ack) begin
                        state_d = S_FETCH;
                    end else begin
                        // Remember the address still on the bus until it completes.
                        stale_pc_d = fetch_pc_q;
                        state_d    = S_DISCARD;
                    end
                end else if (imem_ack) begin
                    ir_d       = imem_rdata;
                    ir_pc4_d   = pc_inc_s;
                    ir_valid_d = 1'b1;
                    fetch_pc_d = pc_inc_s;
                    state_d    = S_FULL;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FULL: begin
                if (redirect) begin
                    fetch_pc_d = target_s;
                    ir_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end else if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_FULL;
                end
            end
            S_DISCARD: begin
                ir_valid_d = 1'b0;
                if (redirect) begin
                    fetch_pc_d = target_s;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                if (imem_ack) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DISCARD;
                end
            end
            default: begin
                ir_valid_d = 1'b0;
                state_d    = S_FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            stale_pc_q <= 32'd0;
            ir_q       <= 32'd0;
            ir_pc4_q   <= 32'd0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            stale_pc_q <= stale_pc_d;
            ir_q       <= ir_d;
            ir_pc4_q   <= ir_pc4_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // Reset gates the request so nothing is issued while reset is held.
    assign imem_req  = !reset && (state_q != S_FULL);
    assign imem_addr = (state_q == S_DISCARD) ? stale_pc_q : fetch_pc_q;
    assign ir_valid  = ir_valid_q;
    assign ir        = ir_q;
    assign ir_pc4    = ir_pc4_q;
    assign opcode    = ir_q[31:28];
    assign opfunc    = ir_q[27:24];

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch: reset, zero-wait fetch, stall,
// redirect while waiting / with ack / in DISCARD, address wrap, reset mid-request.
module tb_ifetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  opfunc;
    logic [31:0] ir_pc4;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    ifetch dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir         (ir),
        .opcode     (opcode),
        .opfunc     (opfunc),
        .ir_pc4     (ir_pc4),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; ir_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0;
        step(); step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_pc4", ir_pc4, 32'd0);

        reset = 1'b0;
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0000_0000);

        // zero-wait fetch at 0
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        chk("f0_valid", {31'd0, ir_valid}, 32'd1);
        chk("f0_ir", ir, 32'h1234_5678);
        chk("f0_opcode", {28'd0, opcode}, 32'h1);
        chk("f0_opfunc", {28'd0, opfunc}, 32'h2);
        chk("f0_pc4", ir_pc4, 32'h4);
        chk("f0_req", {31'd0, imem_req}, 32'd0);

        // stall 5 cycles, with a spurious ack that must be ignored
        for (int i = 0; i < 5; i++) begin
            imem_ack = (i == 2); imem_rdata = 32'hDEAD_BEEF;
            step();
            chk("stall_valid", {31'd0, ir_valid}, 32'd1);
            chk("stall_ir", ir, 32'h1234_5678);
            chk("stall_pc4", ir_pc4, 32'h4);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        imem_ack = 1'b0; ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        chk("rel_valid", {31'd0, ir_valid}, 32'd0);
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h4);

        imem_ack = 1'b1; imem_rdata = 32'h2500_0000;
        step();
        imem_ack = 1'b0; ir_ready = 1'b1;
        chk("f4_opcode", {28'd0, opcode}, 32'h2);
        chk("f4_pc4", ir_pc4, 32'h8);
        step();
        ir_ready = 1'b0;
        chk("f8_addr", imem_addr, 32'h8);
        chk("f8_req", {31'd0, imem_req}, 32'd1);

        // redirect while request at 8 is waiting
        step();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        chk("disc_req", {31'd0, imem_req}, 32'd1);
        chk("disc_addr", imem_addr, 32'h8);
        chk("disc_valid", {31'd0, ir_valid}, 32'd0);
        step();
        chk("disc_addr2", imem_addr, 32'h8);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_0008;
        step();
        imem_ack = 1'b0;
        chk("disc_drop_valid", {31'd0, ir_valid}, 32'd0);
        chk("tgt_addr", imem_addr, 32'h0000_0100);
        step();
        chk("tgt_valid", {31'd0, ir_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h3A00_0001;
        step();
        imem_ack = 1'b0;
        chk("t_ir", ir, 32'h3A00_0001);
        chk("t_opfunc", {28'd0, opfunc}, 32'hA);
        chk("t_pc4", ir_pc4, 32'h104);

        // redirect in FULL overrides concurrent ir_ready
        redirect = 1'b1; redirect_pc = 32'h0000_0200; ir_ready = 1'b1;
        step();
        redirect = 1'b0; ir_ready = 1'b0;
        chk("full_redir_valid", {31'd0, ir_valid}, 32'd0);
        chk("full_redir_addr", imem_addr, 32'h200);

        // redirect and ack in the same cycle
        redirect = 1'b1; redirect_pc = 32'h0000_0306; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        step();
        redirect = 1'b0; imem_ack = 1'b0;
        chk("same_valid", {31'd0, ir_valid}, 32'd0);
        chk("same_addr", imem_addr, 32'h304);

        // DISCARD keeps latest redirect target
        redirect = 1'b1; redirect_pc = 32'h0000_0400;
        step();
        redirect_pc = 32'h0000_0500;
        step();
        redirect = 1'b0;
        chk("disc2_addr", imem_addr, 32'h304);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("disc2_tgt", imem_addr, 32'h500);
        chk("disc2_valid", {31'd0, ir_valid}, 32'd0);

        // wrap at top of address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; imem_ack = 1'b1;
        step();
        redirect = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_rdata = 32'h4100_0000;
        step();
        imem_ack = 1'b0; ir_ready = 1'b1;
        chk("wrap_pc4", ir_pc4, 32'h0);
        chk("wrap_ir", ir, 32'h4100_0000);
        step();
        ir_ready = 1'b0;
        chk("wrap_next", imem_addr, 32'h0);

        // reset with request outstanding, ack arrives one cycle later
        reset = 1'b1;
        step();
        chk("rst2_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        step();
        chk("rst2_valid", {31'd0, ir_valid}, 32'd0);
        reset = 1'b0; imem_ack = 1'b0;
        step();
        chk("rst2_req1", {31'd0, imem_req}, 32'd1);
        chk("rst2_addr", imem_addr, 32'h0);
        chk("rst2_ir", ir, 32'h0);
        chk("rst2_valid2", {31'd0, ir_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
